// File: rtl/gg_pkg.sv
// gg_pkg: shared FSM state type, default gain constant and saturation helper for gg_col
package gg_pkg;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ROT, S_OUT} state_t;
    localparam int unsigned K_Q8_DEF = 155;
    function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction
endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one combinational CORDIC vectoring micro-iteration
// Ports: x_i/y_i current vector, shift_i iteration index; x_o/y_o rotated vector, d_o direction (1 = signs differ)
module cordic_vec_stage #(
    parameter int IW = 19,
    parameter int SW = 4
) (
    input  logic signed [IW-1:0] x_i,
    input  logic signed [IW-1:0] y_i,
    input  logic [SW-1:0]        shift_i,
    output logic signed [IW-1:0] x_o,
    output logic signed [IW-1:0] y_o,
    output logic                 d_o
);
    logic signed [IW-1:0] x_sh, y_sh;
    assign x_sh = x_i >>> shift_i;
    assign y_sh = y_i >>> shift_i;
    assign d_o  = x_i[IW-1] ^ y_i[IW-1];
    assign x_o  = d_o ? x_i - y_sh : x_i + y_sh;
    assign y_o  = d_o ? y_i + x_sh : y_i - x_sh;
endmodule

// File: rtl/gg_col.sv
// gg_col: CORDIC vectoring Givens generator folding a matrix column into a running pivot
// Ports: clk_i/rst_ni clock and async active-low reset; in_* element handshake with
// first/last column markers; dir_* per-cycle direction chunks (no backpressure);
// out_* saturated, gain-compensated column norm handshake.
module gg_col
    import gg_pkg::*;
#(
    parameter int          DATA_W = 13,
    parameter int          GUARD  = 4,
    parameter int          ITER   = 12,
    parameter int          UNROLL = 3,
    parameter int unsigned K_Q8   = K_Q8_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic signed [DATA_W-1:0] in_data_i,
    input  logic                     in_first_i,
    input  logic                     in_last_i,
    output logic                     dir_valid_o,
    output logic [UNROLL-1:0]        dir_bits_o,
    output logic                     dir_last_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [DATA_W-1:0] out_data_o
);
    localparam int         IW  = DATA_W + GUARD + 2;
    localparam int         CYC = ITER / UNROLL;
    localparam int         CW  = $clog2(CYC + 1);
    localparam int         SW  = $clog2(ITER + 1);
    localparam logic [7:0] K8  = 8'(K_Q8);

    state_t                   state_q;
    logic signed [IW-1:0]     x_q, y_q, pivot_q, data_ext, scaled;
    logic signed [IW+8:0]     prod;
    logic [CW-1:0]            c_q;
    logic                     last_q, in_ready_q, out_valid_q, acc, start;
    logic signed [DATA_W-1:0] out_data_q;
    logic signed [IW-1:0]     xs [UNROLL+1];
    logic signed [IW-1:0]     ys [UNROLL+1];
    logic [UNROLL-1:0]        d;

    assign xs[0] = x_q;
    assign ys[0] = y_q;
    for (genvar j = 0; j < UNROLL; j++) begin : g_stage
        cordic_vec_stage #(.IW(IW), .SW(SW)) u_stage (
            .x_i    (xs[j]),
            .y_i    (ys[j]),
            .shift_i(SW'(int'(c_q) * UNROLL + j)),
            .x_o    (xs[j+1]),
            .y_o    (ys[j+1]),
            .d_o    (d[j])
        );
    end

    // Gain compensation on the final chunk's x; K is unsigned so it is zero-extended before the signed multiply
    assign prod     = xs[UNROLL] * $signed({1'b0, K8});
    assign scaled   = IW'(prod >>> 8);
    assign data_ext = IW'(in_data_i) <<< GUARD;
    assign acc      = in_valid_i & in_ready_q;
    // Any element arriving in IDLE opens a column, as does an explicit first marker
    assign start    = in_first_i | (state_q == S_IDLE);

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign dir_valid_o = state_q == S_ROT;
    assign dir_bits_o  = dir_valid_o ? d : '0;
    assign dir_last_o  = dir_valid_o && c_q == CW'(CYC - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            pivot_q     <= '0;
            c_q         <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_WAIT: begin
                    in_ready_q <= 1'b1;
                    if (acc) begin
                        if (start && in_last_i) begin
                            pivot_q     <= data_ext;
                            out_data_q  <= in_data_i;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= S_OUT;
                        end else if (start) begin
                            pivot_q <= data_ext;
                            state_q <= S_WAIT;
                        end else begin
                            x_q        <= pivot_q;
                            y_q        <= data_ext;
                            c_q        <= '0;
                            last_q     <= in_last_i;
                            in_ready_q <= 1'b0;
                            state_q    <= S_ROT;
                        end
                    end
                end
                S_ROT: begin
                    x_q <= xs[UNROLL];
                    y_q <= ys[UNROLL];
                    c_q <= c_q + CW'(1);
                    if (c_q == CW'(CYC - 1)) begin
                        c_q         <= '0;
                        pivot_q     <= scaled;
                        out_data_q  <= DATA_W'(sat(32'(scaled >>> GUARD), DATA_W));
                        out_valid_q <= last_q;
                        in_ready_q  <= !last_q;
                        state_q     <= last_q ? S_OUT : S_WAIT;
                    end
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gg_col.sv
// tb_gg_col: directed and random column checks of gg_col against a Euclidean-norm reference
module tb_gg_col;
    localparam int CYC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic signed [12:0] in_data = '0;
    logic in_ready, dir_valid, dir_last, out_valid;
    logic [2:0] dir_bits;
    logic signed [12:0] out_data;

    int n_assert = 0;
    int n_fail = 0;
    int dir_cnt = 0;
    int col[$];
    logic [2:0] fb;
    logic dor;

    always #5 clk = ~clk;

    always @(posedge clk) if (dir_valid === 1'b1) dir_cnt++;

    gg_col dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .in_first_i (in_first),
        .in_last_i  (in_last),
        .dir_valid_o(dir_valid),
        .dir_bits_o (dir_bits),
        .dir_last_o (dir_last),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic signed [31:0] obs, input int lo, input int hi);
        n_assert++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Reference: magnitude is the Euclidean norm, sign follows the first element; each fold
    // loses up to ~0.4% through the rounded gain constant, plus a few LSB of truncation.
    function automatic void model(output int lo, output int hi);
        real s, r;
        int f, lo_m, hi_m;
        s = 0.0;
        foreach (col[i]) s += real'(col[i]) * real'(col[i]);
        r = $sqrt(s);
        f = col.size() - 1;
        if (f == 0) begin
            lo = col[0];
            hi = col[0];
            return;
        end
        lo_m = int'($floor(r - r * 0.004 * f - 3.0));
        hi_m = int'($ceil(r + 3.0));
        if (col[0] < 0) begin
            lo = -hi_m;
            hi = -lo_m;
            lo = lo < -4096 ? -4096 : lo;
            hi = hi < -4096 ? -4096 : hi;
        end else begin
            lo = lo_m > 4095 ? 4095 : lo_m;
            hi = hi_m > 4095 ? 4095 : hi_m;
        end
    endfunction

    task automatic send(input logic signed [12:0] d, input logic f, input logic l);
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", k < 50, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_first = f;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_col(output logic signed [31:0] res);
        int d0;
        d0  = dir_cnt;
        dor = 1'b0;
        fb  = '0;
        for (int e = 0; e < col.size(); e++) begin
            send(13'(col[e]), e == 0, e == col.size() - 1);
            if (e > 0) begin
                for (int c = 0; c < CYC; c++) begin
                    if (e == 1 && c == 0) fb = dir_bits;
                    dor |= |dir_bits;
                    chk("dir_valid", dir_valid, 1);
                    chk("dir_last", dir_last, c == CYC - 1);
                    @(negedge clk);
                end
            end
        end
        chk("out_valid", out_valid, 1);
        chk("dir_count", dir_cnt - d0, CYC * (col.size() - 1));
        res = out_data;
        if (out_ready) begin
            @(negedge clk);
            chk("out_drop", out_valid, 0);
            chk("ready_back", in_ready, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [31:0] res;
        int lo, hi, n, d0;
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dir_valid", dir_valid, 0);
        chk("rst_dir_bits", dir_bits, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        col = {300, 400};
        run_col(res);
        chk_rng("c300_400", res, 497, 500);
        chk("c300_400_d", fb, 3'b100);

        col = {-300, 400};
        run_col(res);
        chk_rng("cm300_400", res, -500, -497);
        chk("cm300_400_d0", fb[0], 1);

        col = {-7};
        run_col(res);
        chk("pass_m7", res, -7);

        col = {4095, 4095, 4095};
        run_col(res);
        chk("sat_pos", res, 4095);

        col = {-4096, -4096};
        run_col(res);
        chk("sat_neg", res, -4096);

        col = {0, 0};
        run_col(res);
        chk("zero_norm", res, 0);
        chk("zero_dirs", dor, 0);

        out_ready = 1'b0;
        col = {300, 400};
        run_col(res);
        chk_rng("bp_norm", res, 497, 500);
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk_rng("bp_data", out_data, 497, 500);
            chk("bp_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        out_ready = 1'b1;

        d0 = dir_cnt;
        send(100, 1'b1, 1'b0);
        send(50, 1'b1, 1'b0);
        chk("restart_no_dir", dir_cnt - d0, 0);
        chk("restart_no_out", out_valid, 0);
        send(120, 1'b0, 1'b1);
        repeat (CYC) @(negedge clk);
        chk("restart_valid", out_valid, 1);
        chk_rng("restart_norm", out_data, 127, 131);
        chk("restart_dirs", dir_cnt - d0, CYC);
        @(negedge clk);

        send(300, 1'b1, 1'b0);
        send(400, 1'b0, 1'b1);
        @(negedge clk);
        chk("midrot_active", dir_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrot_rst_dir", dir_valid, 0);
        chk("midrot_rst_bits", dir_bits, 0);
        chk("midrot_rst_last", dir_last, 0);
        chk("midrot_rst_out", out_valid, 0);
        chk("midrot_rst_data", out_data, 0);
        chk("midrot_rst_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrot_ready", in_ready, 1);
        chk("midrot_dir_after", dir_valid, 0);
        chk("midrot_out_after", out_valid, 0);

        repeat (20) begin
            n = int'($urandom_range(1, 4));
            col.delete();
            repeat (n) col.push_back(int'($urandom_range(0, 2000)) - 1000);
            run_col(res);
            model(lo, hi);
            chk_rng("rand_norm", res, lo, hi);
            if (n > 1) chk("rand_d0", fb[0], (col[0] < 0) != (col[1] < 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
